// File: rtl/vga_pkg.sv
// Shared types and default 640x480@60 raster timing for the VGA output path.
package vga_pkg;

    typedef logic [9:0] coord_t;

    typedef struct packed {
        logic hs;
        logic vs;
        logic blank_n;
    } vga_ctl_t;

    localparam int CTL_W = $bits(vga_ctl_t);

    // Inactive control word: both syncs high, video blanked.
    localparam vga_ctl_t CTL_IDLE = '{hs: 1'b1, vs: 1'b1, blank_n: 1'b0};

    localparam int DEF_H_VISIBLE = 640;
    localparam int DEF_H_FP      = 16;
    localparam int DEF_H_SYNC    = 96;
    localparam int DEF_H_BP      = 48;
    localparam int DEF_V_VISIBLE = 480;
    localparam int DEF_V_FP      = 10;
    localparam int DEF_V_SYNC    = 2;
    localparam int DEF_V_BP      = 33;

    function automatic int scan_total(input int visible, input int fp, input int sync, input int bp);
        return visible + fp + sync + bp;
    endfunction

endpackage

// File: rtl/vga_ctl_delay.sv
// Pixel-rate delay line for {hs, vs, blank_n}; DEPTH = 0 gives a plain per-Clk register.
module vga_ctl_delay
    import vga_pkg::*;
#(
    parameter int DEPTH = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             pix_tick,
    input  logic [CTL_W-1:0] ctl_in,
    output logic [CTL_W-1:0] ctl_out
);

    localparam int NSTAGE = (DEPTH == 0) ? 1 : DEPTH;

    logic     shift_en;
    vga_ctl_t stage_reg [NSTAGE];

    // With no pixel delay the single stage simply re-registers every Clk.
    assign shift_en = (DEPTH == 0) ? 1'b1 : pix_tick;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NSTAGE; i++) begin
                stage_reg[i] <= CTL_IDLE;
            end
        end else if (shift_en) begin
            stage_reg[0] <= vga_ctl_t'(ctl_in);
            for (int i = 1; i < NSTAGE; i++) begin
                stage_reg[i] <= stage_reg[i-1];
            end
        end
    end

    assign ctl_out = stage_reg[NSTAGE-1];

endmodule

// File: rtl/vga_timing_gen.sv
// Raster timing source: Clk/2 pixel rate, 800x525 scan, delayed sync/blank, frame pulse.
module vga_timing_gen
    import vga_pkg::*;
#(
    parameter int H_VISIBLE = DEF_H_VISIBLE,
    parameter int H_FP      = DEF_H_FP,
    parameter int H_SYNC    = DEF_H_SYNC,
    parameter int H_BP      = DEF_H_BP,
    parameter int V_VISIBLE = DEF_V_VISIBLE,
    parameter int V_FP      = DEF_V_FP,
    parameter int V_SYNC    = DEF_V_SYNC,
    parameter int V_BP      = DEF_V_BP,
    parameter int PIPE_DLY  = 1
) (
    input  logic       Clk,
    input  logic       Reset_n,
    output logic       VGA_CLK,
    output logic       pix_tick,
    output logic [9:0] DrawX,
    output logic [9:0] DrawY,
    output logic       VGA_HS,
    output logic       VGA_VS,
    output logic       VGA_BLANK_N,
    output logic       VGA_SYNC_N,
    output logic       frame_start
);

    localparam int     H_TOTAL    = scan_total(H_VISIBLE, H_FP, H_SYNC, H_BP);
    localparam int     V_TOTAL    = scan_total(V_VISIBLE, V_FP, V_SYNC, V_BP);
    localparam coord_t H_LAST     = coord_t'(H_TOTAL - 1);
    localparam coord_t V_LAST     = coord_t'(V_TOTAL - 1);
    localparam coord_t H_ACT      = coord_t'(H_VISIBLE);
    localparam coord_t V_ACT      = coord_t'(V_VISIBLE);
    localparam coord_t V_ACT_LAST = coord_t'(V_VISIBLE - 1);
    localparam coord_t HS_START   = coord_t'(H_VISIBLE + H_FP);
    localparam coord_t HS_END     = coord_t'(H_VISIBLE + H_FP + H_SYNC);
    localparam coord_t VS_START   = coord_t'(V_VISIBLE + V_FP);
    localparam coord_t VS_END     = coord_t'(V_VISIBLE + V_FP + V_SYNC);

    logic     div_reg;
    coord_t   hc_reg, hc_next;
    coord_t   vc_reg, vc_next;
    logic     frame_start_reg, frame_start_next;
    vga_ctl_t ctl_raw;
    vga_ctl_t ctl_dly;

    always_comb begin
        hc_next          = hc_reg;
        vc_next          = vc_reg;
        frame_start_next = 1'b0;
        if (div_reg) begin
            if (hc_reg == H_LAST) begin
                hc_next          = '0;
                vc_next          = (vc_reg == V_LAST) ? '0 : vc_reg + coord_t'(1);
                // Counters are about to land on (0, V_VISIBLE): start of vertical blanking.
                frame_start_next = (vc_reg == V_ACT_LAST);
            end else begin
                hc_next = hc_reg + coord_t'(1);
            end
        end
    end

    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            div_reg         <= 1'b0;
            hc_reg          <= '0;
            vc_reg          <= '0;
            frame_start_reg <= 1'b0;
        end else begin
            div_reg         <= ~div_reg;
            hc_reg          <= hc_next;
            vc_reg          <= vc_next;
            frame_start_reg <= frame_start_next;
        end
    end

    always_comb begin
        ctl_raw         = CTL_IDLE;
        ctl_raw.hs      = !((hc_reg >= HS_START) && (hc_reg < HS_END));
        ctl_raw.vs      = !((vc_reg >= VS_START) && (vc_reg < VS_END));
        ctl_raw.blank_n = (hc_reg < H_ACT) && (vc_reg < V_ACT);
    end

    vga_ctl_delay #(
        .DEPTH(PIPE_DLY)
    ) u_ctl_delay (
        .clk     (Clk),
        .rst_n   (Reset_n),
        .pix_tick(div_reg),
        .ctl_in  (ctl_raw),
        .ctl_out (ctl_dly)
    );

    assign VGA_CLK     = div_reg;
    assign pix_tick    = div_reg;
    assign DrawX       = hc_reg;
    assign DrawY       = vc_reg;
    assign VGA_HS      = ctl_dly.hs;
    assign VGA_VS      = ctl_dly.vs;
    assign VGA_BLANK_N = ctl_dly.blank_n;
    assign VGA_SYNC_N  = 1'b0;
    assign frame_start = frame_start_reg;

endmodule

// File: tb/tb_vga_timing_gen.sv
// Bench: three full-size instances (PIPE_DLY 0/1/3) for line timing, one reduced-geometry instance for frame timing.
module tb_vga_timing_gen;

    localparam int DEF_HV = 640;
    localparam int DEF_HFP = 16;
    localparam int DEF_HS = 96;

    localparam int S_HV = 16;
    localparam int S_HFP = 2;
    localparam int S_HS = 4;
    localparam int S_HBP = 3;
    localparam int S_VV = 10;
    localparam int S_VFP = 2;
    localparam int S_VS = 2;
    localparam int S_VBP = 3;
    localparam int S_HT = S_HV + S_HFP + S_HS + S_HBP;
    localparam int S_VT = S_VV + S_VFP + S_VS + S_VBP;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic s_rst_n = 1'b0;

    int checks = 0;
    int errors = 0;
    int pending_def[3];

    logic       vclk[3], ptick[3], hs[3], vs[3], bl[3], syncn[3], fs[3];
    logic [9:0] dx[3], dy[3];

    logic       s_vclk, s_tick, s_hs, s_vs, s_bl, s_syncn, s_fs;
    logic [9:0] s_dx, s_dy;

    int unsigned q_wrap[$];
    int unsigned q_vs_y[$], q_vs_w[$], q_fs_y[$], q_fs_w[$], q_fs_per[$], q_lines[$], q_corner[$];

    always #5 clk = ~clk;

    task automatic check(input string tag, input int unsigned obs, input int unsigned exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    for (genvar gi = 0; gi < 3; gi++) begin : g_def
        localparam int PD = (gi == 0) ? 0 : (gi == 1) ? 1 : 3;

        vga_timing_gen #(.PIPE_DLY(PD)) u_dut (
            .Clk        (clk),
            .Reset_n    (rst_n),
            .VGA_CLK    (vclk[gi]),
            .pix_tick   (ptick[gi]),
            .DrawX      (dx[gi]),
            .DrawY      (dy[gi]),
            .VGA_HS     (hs[gi]),
            .VGA_VS     (vs[gi]),
            .VGA_BLANK_N(bl[gi]),
            .VGA_SYNC_N (syncn[gi]),
            .frame_start(fs[gi])
        );

        int unsigned q_fall[$], q_low[$], q_blank[$];

        initial begin
            logic        hs_prev, bl_prev;
            int unsigned lo_cnt, hi_cnt;
            hs_prev = 1'b1;
            bl_prev = 1'b0;
            lo_cnt  = 0;
            hi_cnt  = 0;
            pending_def[gi] = 0;
            @(posedge rst_n);
            for (int i = 0; i < 3; i++) begin
                q_fall.push_back(DEF_HV + DEF_HFP + PD);
                q_low.push_back(2 * DEF_HS);
                q_blank.push_back(2 * DEF_HV);
            end
            forever begin
                @(negedge clk);
                if (rst_n) begin
                    if (hs_prev && !hs[gi]) begin
                        if (q_fall.size() > 0)
                            check($sformatf("hs_fall_x_dly%0d", PD), int'(dx[gi]), q_fall.pop_front());
                        lo_cnt = 0;
                    end
                    if (!hs[gi]) lo_cnt++;
                    if (!hs_prev && hs[gi] && q_low.size() > 0)
                        check($sformatf("hs_low_clk_dly%0d", PD), lo_cnt, q_low.pop_front());
                    if (!bl_prev && bl[gi]) hi_cnt = 0;
                    if (bl[gi]) hi_cnt++;
                    if (bl_prev && !bl[gi] && q_blank.size() > 0)
                        check($sformatf("blank_high_clk_dly%0d", PD), hi_cnt, q_blank.pop_front());
                end
                hs_prev = hs[gi];
                bl_prev = bl[gi];
                pending_def[gi] = q_fall.size() + q_low.size() + q_blank.size();
            end
        end
    end

    vga_timing_gen #(
        .H_VISIBLE(S_HV), .H_FP(S_HFP), .H_SYNC(S_HS), .H_BP(S_HBP),
        .V_VISIBLE(S_VV), .V_FP(S_VFP), .V_SYNC(S_VS), .V_BP(S_VBP),
        .PIPE_DLY(1)
    ) u_small (
        .Clk        (clk),
        .Reset_n    (s_rst_n),
        .VGA_CLK    (s_vclk),
        .pix_tick   (s_tick),
        .DrawX      (s_dx),
        .DrawY      (s_dy),
        .VGA_HS     (s_hs),
        .VGA_VS     (s_vs),
        .VGA_BLANK_N(s_bl),
        .VGA_SYNC_N (s_syncn),
        .frame_start(s_fs)
    );

    // Line wrap on the PIPE_DLY=1 full-size instance: 799 -> 0 with DrawY stepping.
    initial begin
        int px;
        px = 0;
        @(posedge rst_n);
        for (int i = 1; i <= 3; i++) q_wrap.push_back(i);
        forever begin
            @(negedge clk);
            if (rst_n && px == 799 && int'(dx[1]) != 799 && q_wrap.size() > 0) begin
                check("wrap_x", int'(dx[1]), 0);
                check("wrap_y", int'(dy[1]), q_wrap.pop_front());
            end
            px = int'(dx[1]);
        end
    end

    // Frame-level monitor on the reduced-geometry instance.
    initial begin
        logic        vs_prev, fs_prev;
        int          py;
        int unsigned vs_cnt, fs_w, per_cnt, line_cnt, cy;
        bit          have_fs;
        vs_prev = 1'b1; fs_prev = 1'b0; py = 0;
        vs_cnt = 0; fs_w = 0; per_cnt = 0; line_cnt = 0; cy = 0; have_fs = 1'b0;
        @(posedge s_rst_n);
        for (int i = 0; i < 3; i++) begin
            q_vs_y.push_back(S_VV + S_VFP);
            q_vs_w.push_back(2 * S_VS * S_HT);
            q_fs_y.push_back(S_VV);
            q_fs_w.push_back(1);
        end
        for (int i = 0; i < 2; i++) begin
            q_fs_per.push_back(2 * S_HT * S_VT);
            q_lines.push_back(S_VT);
            q_corner.push_back(0);
        end
        forever begin
            @(negedge clk);
            if (s_rst_n) begin
                per_cnt++;
                if (int'(s_dy) != py) begin
                    line_cnt++;
                    if (py == S_VT - 1 && q_corner.size() > 0) begin
                        cy = q_corner.pop_front();
                        check("corner_y", int'(s_dy), cy);
                        check("corner_x", int'(s_dx), 0);
                    end
                end
                if (vs_prev && !s_vs) begin
                    if (q_vs_y.size() > 0) begin
                        check("vs_fall_y", int'(s_dy), q_vs_y.pop_front());
                        check("vs_fall_x", int'(s_dx), 1);
                    end
                    vs_cnt = 0;
                end
                if (!s_vs) vs_cnt++;
                if (!vs_prev && s_vs && q_vs_w.size() > 0)
                    check("vs_low_clk", vs_cnt, q_vs_w.pop_front());
                if (!fs_prev && s_fs) begin
                    if (q_fs_y.size() > 0) begin
                        check("fs_y", int'(s_dy), q_fs_y.pop_front());
                        check("fs_x", int'(s_dx), 0);
                    end
                    if (have_fs && q_fs_per.size() > 0) check("fs_period_clk", per_cnt, q_fs_per.pop_front());
                    if (have_fs && q_lines.size() > 0) check("lines_per_frame", line_cnt, q_lines.pop_front());
                    have_fs  = 1'b1;
                    per_cnt  = 0;
                    line_cnt = 0;
                    fs_w     = 0;
                end
                if (s_fs) fs_w++;
                if (fs_prev && !s_fs && q_fs_w.size() > 0)
                    check("fs_width_clk", fs_w, q_fs_w.pop_front());
            end
            vs_prev = s_vs;
            fs_prev = s_fs;
            py      = int'(s_dy);
        end
    end

    function automatic int pending_all();
        return pending_def[0] + pending_def[1] + pending_def[2] + q_wrap.size()
             + q_vs_y.size() + q_vs_w.size() + q_fs_y.size() + q_fs_w.size()
             + q_fs_per.size() + q_lines.size() + q_corner.size();
    endfunction

    initial begin
        int glitch;
        int n;
        bit found;

        repeat (5) @(negedge clk);
        for (int k = 0; k < 3; k++) begin
            check($sformatf("rst_x%0d", k), int'(dx[k]), 0);
            check($sformatf("rst_y%0d", k), int'(dy[k]), 0);
            check($sformatf("rst_hs%0d", k), int'(hs[k]), 1);
            check($sformatf("rst_vs%0d", k), int'(vs[k]), 1);
            check($sformatf("rst_blank%0d", k), int'(bl[k]), 0);
            check($sformatf("rst_vgaclk%0d", k), int'(vclk[k]), 0);
            check($sformatf("rst_fs%0d", k), int'(fs[k]), 0);
            check($sformatf("sync_n%0d", k), int'(syncn[k]), 0);
        end
        check("rst_s_x", int'(s_dx), 0);
        check("rst_s_hs", int'(s_hs), 1);
        check("rst_s_vs", int'(s_vs), 1);
        check("rst_s_vgaclk", int'(s_vclk), 0);
        check("sync_n_s", int'(s_syncn), 0);

        rst_n   = 1'b1;
        s_rst_n = 1'b1;
        @(negedge clk);
        for (int k = 0; k < 3; k++) begin
            check($sformatf("clk1_tick%0d", k), int'(ptick[k]), 1);
            check($sformatf("clk1_x%0d", k), int'(dx[k]), 0);
        end
        @(negedge clk);
        for (int k = 0; k < 3; k++) begin
            check($sformatf("clk2_tick%0d", k), int'(ptick[k]), 0);
            check($sformatf("clk2_x%0d", k), int'(dx[k]), 1);
        end

        n = 0;
        while (pending_all() != 0 && n < 6000) begin
            @(negedge clk);
            n++;
        end
        check("pending_expectations", pending_all(), 0);

        // Mid-frame reset on the small instance while its HS is active.
        found = 1'b0;
        n = 0;
        while (!found && n < 2000) begin
            @(negedge clk);
            n++;
            if (!s_hs && int'(s_dy) == 6) found = 1'b1;
        end
        check("mid_hs_low_found", int'(found), 1);
        s_rst_n = 1'b0;
        #1;
        check("mid_rst_hs", int'(s_hs), 1);
        check("mid_rst_vs", int'(s_vs), 1);
        check("mid_rst_blank", int'(s_bl), 0);
        check("mid_rst_x", int'(s_dx), 0);
        check("mid_rst_y", int'(s_dy), 0);
        @(negedge clk);
        @(negedge clk);
        s_rst_n = 1'b1;
        @(negedge clk);
        check("mid_clk1_tick", int'(s_tick), 1);
        check("mid_clk1_x", int'(s_dx), 0);
        @(negedge clk);
        check("mid_clk2_x", int'(s_dx), 1);
        check("mid_clk2_y", int'(s_dy), 0);

        glitch = 0;
        n = 0;
        while (int'(s_dx) < S_HV + S_HFP && n < 200) begin
            if (!s_hs) glitch++;
            @(negedge clk);
            n++;
        end
        check("mid_hs_glitch", glitch, 0);
        n = 0;
        while (s_hs && n < 200) begin
            @(negedge clk);
            n++;
        end
        check("mid_hs_fall_x", int'(s_dx), S_HV + S_HFP + 1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

endmodule

// File: doc/vga_timing_gen.md
# vga_timing_gen

Raster timing source for the 640x480@60 Hz VGA output path. Divides the 50 MHz system clock to a 25 MHz pixel rate and scans horizontal/vertical counters across an 800x525 frame. Drives DrawX/DrawY to the color mapper and the sprite RAM address logic, and drives VGA_HS/VGA_VS/VGA_BLANK_N to the DAC. Sync and blank are delayed by a configurable number of pixels so they line up with the registered sprite-RAM colour data. Also emits a once-per-frame pulse that steps the game-object (Pac-Man, ghost) position logic.

## Interface
- H_VISIBLE, 640, active pixels per line
- H_FP, 16, horizontal front porch (pixels)
- H_SYNC, 96, horizontal sync width (pixels)
- H_BP, 48, horizontal back porch (pixels)
- V_VISIBLE, 480, active lines per frame
- V_FP, 10, vertical front porch (lines)
- V_SYNC, 2, vertical sync width (lines)
- V_BP, 33, vertical back porch (lines)
- PIPE_DLY, 1, pixel-tick delay of sync/blank relative to DrawX/DrawY; legal range 0..4

Ports:
- Clk  in  1  50 MHz system clock
- Reset_n  in  1  asynchronous, active-low reset
- VGA_CLK  out  1  25 MHz pixel clock (Clk/2)
- pix_tick  out  1  one-Clk strobe; counters advance on this cycle
- DrawX  out  10  horizontal counter, 0..799
- DrawY  out  10  vertical counter, 0..524
- VGA_HS  out  1  horizontal sync, active low, delayed PIPE_DLY ticks
- VGA_VS  out  1  vertical sync, active low, delayed PIPE_DLY ticks
- VGA_BLANK_N  out  1  high in the visible region, delayed PIPE_DLY ticks
- VGA_SYNC_N  out  1  constant 0
- frame_start  out  1  one-Clk pulse at the start of vertical blanking

## Operation
- Divider: 1-bit `div` toggles every Clk. VGA_CLK = div. pix_tick = (div == 1).
- Horizontal counter `hc` increments on pix_tick. At H_TOTAL-1 (799) it wraps to 0, and `vc` increments on that same tick.
- Vertical counter `vc` wraps to 0 after V_TOTAL-1 (524), on the tick where hc also wraps.
- H_TOTAL = sum of the four H parameters; V_TOTAL likewise. All compares are 10-bit unsigned.
- Undelayed sync: hs_raw = 0 iff H_VISIBLE+H_FP <= hc < H_VISIBLE+H_FP+H_SYNC (656..751).
- Undelayed sync: vs_raw = 0 iff V_VISIBLE+V_FP <= vc < V_VISIBLE+V_FP+V_SYNC (490..491).
- Undelayed blank: blank_raw_n = (hc < H_VISIBLE) && (vc < V_VISIBLE).
- DrawX = hc and DrawY = vc, registered and undelayed. Consumers register sprite-RAM data PIPE_DLY times, so colour lands aligned with the delayed sync/blank.
- Delay line: {hs, vs, blank_n} shift by one stage per pix_tick and hold between ticks. With PIPE_DLY = 0, the outputs are the raw values registered on Clk.
- frame_start: asserted for exactly one Clk, on the Clk edge where the counters move to hc = 0, vc = V_VISIBLE. Equivalently, the pix_tick cycle where hc = 799 and vc = 479.

## Timing
- Reset values (asynchronous, on Reset_n low):
  - div = 0, hc = vc = 0, DrawX = DrawY = 0
  - VGA_HS = VGA_VS = 1 (inactive)
  - VGA_BLANK_N = 0, frame_start = 0
  - every delay stage = {1, 1, 0}
- Reset deassertion mid-frame: the scan restarts at (0, 0). No partial sync pulse may be emitted after release, because the delay stages are already inactive.
- First pix_tick is on the 2nd Clk after release (div goes 0 → 1).
- Line period is 1600 Clk. Frame period is 840000 Clk.
- hs_raw falls on the tick that makes hc = 656. VGA_HS falls PIPE_DLY ticks later, i.e. 2·PIPE_DLY Clk later.
- Corner wrap (hc = 799, vc = 524): both counters return to 0 on the same tick. No extra line and no skipped line.
- frame_start and the vc → 480 transition are on the same Clk edge.

## Structure
- Package `vga_pkg`:
  - localparams for the default timing and H_TOTAL/V_TOTAL functions
  - typedef `coord_t` = logic [9:0]
  - typedef struct `vga_ctl_t` {hs, vs, blank_n}
- Sub-module `vga_ctl_delay`:
  - parameter DEPTH
  - shift register of vga_ctl_t, enabled by pix_tick, with asynchronous reset to {1, 1, 0}
  - instantiated once with DEPTH = PIPE_DLY

## Test plan
- Reset behaviour: hold Reset_n = 0 for 5 Clk.
  - During reset: DrawX = DrawY = 0, VGA_HS = VGA_VS = 1, VGA_BLANK_N = 0, VGA_CLK = 0.
  - After release: first pix_tick on Clk 2; DrawX = 1 after Clk 2.
- Horizontal sync and blank (PIPE_DLY = 1), over one line:
  - VGA_BLANK_N high for exactly 640 ticks.
  - VGA_HS low for exactly 96 ticks, falling at DrawX = 657.
  - hc wraps 799 → 0 as DrawY increments.
- Full frame:
  - VGA_VS low for 2 lines (3200 Clk), starting when DrawY = 490 (vs_raw), seen 1 tick later.
  - 525 lines per frame; frame period 840000 Clk.
- frame_start:
  - Exactly one 1-Clk pulse per frame, coincident with DrawY becoming 480 and DrawX = 0.
  - Two consecutive pulses are 840000 Clk apart.
- PIPE_DLY = 0 and PIPE_DLY = 3: VGA_HS falling edge occurs at DrawX = 656 and DrawX = 659 respectively.
- Mid-frame reset: pulse Reset_n low while VGA_HS = 0 at DrawY = 200.
  - Outputs go inactive immediately.
  - After release the scan restarts at (0, 0).
  - No HS-low glitch appears before DrawX = 656.
